// File: rtl/frame_buffer_write_arbiter.sv
// Write-port arbiter for the camera/VGA frame buffer: camera pixels, a whole-buffer
// clear sequencer and a req/ack processor port share one registered RAM write port.
module frame_buffer_write_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int FILL_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cam_valid,
    input  logic [ADDR_WIDTH-1:0] cam_addr,
    input  logic [DATA_WIDTH-1:0] cam_data,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_ack,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  o_dbg_state
);

    localparam int unsigned           LP_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LP_LAST  = (ADDR_WIDTH+1)'(LP_DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] LP_FILL  = DATA_WIDTH'(FILL_VALUE);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH:0]   r_ptr;
    logic [ADDR_WIDTH:0]   w_next_ptr;

    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_cpu_ack;
    logic                  r_clr_busy;
    logic                  r_clr_done;

    logic                  w_grant_cam;
    logic                  w_grant_clr;
    logic                  w_grant_cpu;
    logic                  w_last_clr;
    logic                  w_next_we;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [DATA_WIDTH-1:0] w_next_data;

    // Processor handshake: cpu_req is a level held with stable addr/data; every cycle
    // it wins arbitration issues one write, and cpu_ack pulses in the same cycle that
    // write appears on mem_*. The requester drops cpu_req in the cycle it sees cpu_ack.
    always_comb begin
        w_grant_cam = 1'b0;
        w_grant_clr = 1'b0;
        w_grant_cpu = 1'b0;
        if (cam_valid) begin
            w_grant_cam = 1'b1;
        end else if (r_state == ST_CLEAR) begin
            w_grant_clr = 1'b1;
        end else if (cpu_req && !clr_start) begin
            w_grant_cpu = 1'b1;
        end
        w_last_clr = w_grant_clr && (r_ptr == LP_LAST);
    end

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clr_start) begin
                    w_next_state = ST_CLEAR;
                    w_next_ptr   = '0;
                end
            end
            ST_CLEAR: begin
                // A camera-preempted cycle leaves the pointer alone so no address is skipped.
                if (w_grant_clr) begin
                    w_next_ptr = r_ptr + (ADDR_WIDTH+1)'(1);
                end
                if (w_last_clr) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_next_we   = 1'b0;
        w_next_addr = r_mem_addr;
        w_next_data = r_mem_data;
        if (w_grant_cam) begin
            w_next_we   = 1'b1;
            w_next_addr = cam_addr;
            w_next_data = cam_data;
        end else if (w_grant_clr) begin
            w_next_we   = 1'b1;
            w_next_addr = r_ptr[ADDR_WIDTH-1:0];
            w_next_data = LP_FILL;
        end else if (w_grant_cpu) begin
            w_next_we   = 1'b1;
            w_next_addr = cpu_addr;
            w_next_data = cpu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_cpu_ack  <= 1'b0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_mem_we   <= w_next_we;
            r_mem_addr <= w_next_addr;
            r_mem_data <= w_next_data;
            r_cpu_ack  <= w_grant_cpu;
            r_clr_busy <= (w_next_state == ST_CLEAR);
            r_clr_done <= w_last_clr;
        end
    end

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_data    = r_mem_data;
    assign cpu_ack     = r_cpu_ack;
    assign clr_busy    = r_clr_busy;
    assign clr_done    = r_clr_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_frame_buffer_write_arbiter.sv
// Directed bench for frame_buffer_write_arbiter: reset, camera stream, processor
// handshake, full clear, clear with camera preemption and reset mid-clear.
module tb_frame_buffer_write_arbiter;

    localparam int DW    = 4;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cam_valid;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_data;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_ack;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          o_dbg_state;

    int n_vec  = 0;
    int n_miss = 0;
    logic [DW-1:0] buf_model [DEPTH];

    frame_buffer_write_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FILL_VALUE (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cam_valid   (cam_valid),
        .cam_addr    (cam_addr),
        .cam_data    (cam_data),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_ack     (cpu_ack),
        .clr_start   (clr_start),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .o_dbg_state (o_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, buffer model updated.
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) buf_model[mem_addr] = mem_data;
    endtask

    task automatic expect_out(input string tag, input logic we, input int addr, input int data,
                              input logic ack, input logic busy, input logic done);
        check_eq({tag, ".we"},   32'(mem_we),   32'(we));
        check_eq({tag, ".addr"}, 32'(mem_addr), 32'(addr));
        check_eq({tag, ".data"}, 32'(mem_data), 32'(data));
        check_eq({tag, ".ack"},  32'(cpu_ack),  32'(ack));
        check_eq({tag, ".busy"}, 32'(clr_busy), 32'(busy));
        check_eq({tag, ".done"}, 32'(clr_done), 32'(done));
        check_eq({tag, ".st"},   32'(o_dbg_state), 32'(busy));
    endtask

    task automatic idle_inputs();
        cam_valid = 1'b0; cam_addr = '0; cam_data = '0;
        cpu_req   = 1'b0; cpu_addr = '0; cpu_data = '0;
        clr_start = 1'b0;
    endtask

    initial begin
        int nonzero;
        for (int i = 0; i < DEPTH; i++) buf_model[i] = 4'hF;
        idle_inputs();

        // reset then idle
        rst = 1'b1;
        step(); step();
        expect_out("reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_out("idle", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        end

        // camera stream: (5,A),(6,B),(7,C) back to back
        for (int i = 0; i < 3; i++) begin
            cam_valid = 1'b1; cam_addr = AW'(5 + i); cam_data = DW'(10 + i);
            step();
            expect_out("cam", 1'b1, 5 + i, 10 + i, 1'b0, 1'b0, 1'b0);
        end
        idle_inputs();
        step();
        expect_out("cam_hold", 1'b0, 7, 12, 1'b0, 1'b0, 1'b0);

        // processor single write
        cpu_req = 1'b1; cpu_addr = 6'd12; cpu_data = 4'd9;
        step();
        expect_out("cpu", 1'b1, 12, 9, 1'b1, 1'b0, 1'b0);
        cpu_req = 1'b0;
        step();
        expect_out("cpu_drop", 1'b0, 12, 9, 1'b0, 1'b0, 1'b0);

        // processor delayed by three camera cycles
        cpu_req = 1'b1; cpu_addr = 6'd13; cpu_data = 4'd5;
        for (int i = 0; i < 3; i++) begin
            cam_valid = 1'b1; cam_addr = AW'(20 + i); cam_data = DW'(1 + i);
            step();
            expect_out("cam_over_cpu", 1'b1, 20 + i, 1 + i, 1'b0, 1'b0, 1'b0);
        end
        cam_valid = 1'b0;
        step();
        expect_out("cpu_late", 1'b1, 13, 5, 1'b1, 1'b0, 1'b0);
        cpu_req = 1'b0;
        step();
        expect_out("cpu_late_drop", 1'b0, 13, 5, 1'b0, 1'b0, 1'b0);

        // full clear; clr_start together with cpu_req -> clear wins, no cpu write
        clr_start = 1'b1; cpu_req = 1'b1; cpu_addr = 6'd40; cpu_data = 4'd3;
        step();
        expect_out("clr_start", 1'b0, 13, 5, 1'b0, 1'b1, 1'b0);
        clr_start = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            clr_start = (i == 20);
            step();
            expect_out("clear", 1'b1, i, 0, 1'b0, i != DEPTH - 1, i == DEPTH - 1);
        end
        clr_start = 1'b0;
        step();
        expect_out("clear_end", 1'b0, DEPTH - 1, 0, 1'b0, 1'b0, 1'b0);
        nonzero = 0;
        for (int i = 0; i < DEPTH; i++) if (buf_model[i] !== 4'd0) nonzero++;
        check_eq("readback_nonzero", 32'(nonzero), 32'd0);

        // clear with camera preemption, start together with a camera write
        clr_start = 1'b1; cam_valid = 1'b1; cam_addr = 6'd50; cam_data = 4'd2;
        step();
        expect_out("clr_cam_start", 1'b1, 50, 2, 1'b0, 1'b1, 1'b0);
        clr_start = 1'b0; cam_valid = 1'b0;
        cpu_req = 1'b1; cpu_addr = 6'd33; cpu_data = 4'd7;
        for (int k = 0; k < DEPTH + 2; k++) begin
            cam_valid = (k == 10 || k == 11);
            cam_addr  = AW'(40 + k - 10);
            cam_data  = DW'(3 + k - 10);
            step();
            if (k == 10 || k == 11)
                expect_out("preempt_cam", 1'b1, 40 + k - 10, 3 + k - 10, 1'b0, 1'b1, 1'b0);
            else if (k < 10)
                expect_out("preempt_clr", 1'b1, k, 0, 1'b0, 1'b1, 1'b0);
            else
                expect_out("preempt_clr", 1'b1, k - 2, 0, 1'b0, k != DEPTH + 1, k == DEPTH + 1);
        end
        cam_valid = 1'b0;
        step();
        expect_out("cpu_after_clr", 1'b1, 33, 7, 1'b1, 1'b0, 1'b0);
        cpu_req = 1'b0;
        step();
        expect_out("cpu_after_drop", 1'b0, 33, 7, 1'b0, 1'b0, 1'b0);

        // reset mid-clear at pointer 30
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            expect_out("pre_rst_clr", 1'b1, i, 0, 1'b0, 1'b1, 1'b0);
        end
        rst = 1'b1;
        step();
        expect_out("mid_rst", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("post_rst", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        end
        clr_start = 1'b1;
        step();
        expect_out("restart", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        clr_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            expect_out("restart_clr", 1'b1, i, 0, 1'b0, i != DEPTH - 1, i == DEPTH - 1);
        end

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/frame_buffer_write_arbiter.md
Name: frame_buffer_write_arbiter

Overview:
- Single-clock arbiter and sequencer for the write port of the dual-port frame buffer RAM in the camera/VGA path.
- Shares the write port between three sources:
  - camera pixel stream: cannot stall, highest priority
  - full-buffer clear/fill sequencer
  - processor write port using a req/ack handshake
- The read port (VGA side) is outside this block.
- All RAM-side outputs are registered and connect directly to the buffer's data, write_addr and we inputs.

Parameters:
- DATA_WIDTH, 4, pixel width; must match the buffer.
- ADDR_WIDTH, 6, buffer address width; depth = 2**ADDR_WIDTH.
- FILL_VALUE, 0, pixel value written by the clear sequencer.

Ports:
- clk  in  1  system clock; also drives the buffer write clock.
- rst  in  1  synchronous, active-high reset.
- cam_valid  in  1  camera pixel present this cycle.
- cam_addr  in  ADDR_WIDTH  camera pixel address.
- cam_data  in  DATA_WIDTH  camera pixel value.
- cpu_req  in  1  processor write request; hold addr/data stable until ack.
- cpu_addr  in  ADDR_WIDTH  processor write address.
- cpu_data  in  DATA_WIDTH  processor write data.
- cpu_ack  out  1  one-cycle pulse; the processor write has been issued.
- clr_start  in  1  start clear of the whole buffer.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse after the last clear write is issued.
- mem_we  out  1  to buffer we.
- mem_addr  out  ADDR_WIDTH  to buffer write_addr.
- mem_data  out  DATA_WIDTH  to buffer data.

Behaviour:
- Reset values: rst high at a clk edge forces the following.
  - mem_we=0, mem_addr=0, mem_data=0
  - cpu_ack=0, clr_busy=0, clr_done=0
  - clear pointer=0, state IDLE
- Reset mid-clear aborts the clear; no clr_done is produced.
- States:
  - IDLE: clr_start=1 -> CLEAR, pointer=0, clr_busy=1 from the next cycle.
  - CLEAR: returns to IDLE when the write at pointer 2**ADDR_WIDTH-1 is issued.
  - clr_start is ignored while in CLEAR.
- Per-cycle grant, evaluated from the current inputs and state. Exactly one winner or none.
  - 1) cam_valid=1: camera wins. Next cycle mem_we=1, mem_addr=cam_addr, mem_data=cam_data.
  - 2) else state CLEAR: clear wins. Next cycle mem_we=1, mem_addr=pointer, mem_data=FILL_VALUE; pointer increments.
  - 3) else cpu_req=1 and state IDLE: processor wins. Next cycle mem_we=1, mem_addr=cpu_addr, mem_data=cpu_data, cpu_ack=1 (same cycle as mem_we).
  - 4) else mem_we=0; mem_addr and mem_data hold their previous values.
- Latency: the winning request appears on the mem_* outputs exactly 1 cycle later. The buffer commits it on the following clk edge.
- Pointer behaviour:
  - Holds when the camera preempts during CLEAR, so no address is skipped.
  - Clear takes 2**ADDR_WIDTH writes plus the number of camera-preempted cycles.
  - Pointer is ADDR_WIDTH+1 bits internally; no wrap is observable.
- clr_done:
  - Pulses in the same cycle that mem_we carries the final clear write (address 2**ADDR_WIDTH-1).
  - clr_busy falls in that same cycle.
  - The state is IDLE from that cycle.
- CPU handshake:
  - The processor is blocked for the entire clear.
  - Each granted cycle produces one write and one cpu_ack.
  - A requester that keeps cpu_req high after seeing cpu_ack gets another write of the current addr/data. Requesters must drop cpu_req in the cycle they observe cpu_ack.
  - cpu_ack is never asserted without a matching mem_we.
- Simultaneous events:
  - clr_start and cpu_req together in IDLE: the clear starts; this cycle's cpu_req is not granted.
  - clr_start and cam_valid together: the camera write is issued and the state still moves to CLEAR.
- Camera writes always pass through; no camera pixel is ever dropped or delayed beyond 1 cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all inputs 0 -> all outputs 0, mem_we never asserted over 10 cycles.
- Camera stream: cam_valid=1 for addr 5,6,7 with data A,B,C on consecutive cycles -> mem_we=1 with (5,A),(6,B),(7,C) one cycle later each, back-to-back.
- CPU handshake: cpu_req=1, addr=12, data=9, dropped after ack -> exactly one cycle of mem_we=1, mem_addr=12, mem_data=9, cpu_ack=1. Repeat with cam_valid=1 for 3 cycles overlapping -> ack delayed until the first cycle without cam_valid.
- Full clear, defaults (64 entries, FILL 0): pulse clr_start -> 64 consecutive writes to addrs 0..63 with data 0; clr_busy high throughout; clr_done coincides with the addr-63 write; read-back via the buffer is all 0.
- Clear with preemption: during a clear, cam_valid=1 at the cycles where pointer=10 and 11 -> camera writes inserted; clear resumes at addr 10; total 66 write cycles; no addr missing or duplicated; a cpu_req held throughout is acked only after clr_done.
- Reset mid-clear: rst=1 when pointer=30 -> mem_we=0 and clr_busy=0 next cycle, no clr_done; a new clr_start restarts at addr 0.
